// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin FIFO read scheduler.
// Holds the scheduler state encoding, the output buffer depth and the
// width helper used to size counters and channel indices.
package fifo_rr_scheduler_pkg;

    // Scheduler FSM states; IDLE must stay encoded as zero so that a cleared
    // state register reads as idle on debug taps.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        BURST = 2'd2
    } sched_state_t;

    // Output skid buffer depth; two entries cover the one-cycle FIFO read
    // latency while still allowing one word per cycle throughput.
    localparam int SCHED_BUF_DEPTH = 2;

    // Number of bits needed to index 'value' distinct items (minimum 1).
    function automatic int clogb2_f(input int value);
        int v;
        int res;
        v   = value - 1;
        res = 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_rr_arbiter.sv
// Combinational rotate-priority arbiter.
// Searches the request vector starting one past ptr_i (wrapping N-1 -> 0
// with an explicit compare so N need not be a power of two) and returns the
// first requester as a one-hot grant, its index, and an any-request flag.
// The pointer register itself lives in the caller.
module rr_arbiter
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = clogb2_f(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [CW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [CW-1:0] idx_o,
    output logic          any_o
);

    logic [CW-1:0] cand;

    // Walk the channels in rotated order and keep the first requester found.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = ptr_i;
        for (int i = 0; i < N; i++) begin
            if (cand == CW'(N - 1)) begin
                cand = '0;
            end else begin
                cand = cand + CW'(1);
            end
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler draining N show-ahead-off FIFOs (1-cycle read
// latency) into a single valid/ready stream tagged with the source channel.
//
// Handshake: a word transfers on a clock edge where valid_o && ready_i are
// both high; once valid_o rises, data_o and ch_o hold steady until that
// transfer happens, and valid_o never drops without a transfer.
//
// Read requests are only raised towards a FIFO that reports non-empty in the
// same cycle, and only when the 2-entry output buffer is guaranteed room for
// the word once it returns, so no FIFO underflows and no word is dropped.
//
// Optional build macro: FIFO_SCHED_STATS_EN adds words_cnt_o, a per-channel
// 32-bit count of words popped on the output stream.
module fifo_rr_scheduler
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int N         = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16,
    parameter int BW        = clogb2_f(MAX_BURST + 1),
    parameter int CW        = clogb2_f(N)
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            en_i,
    input  logic [BW-1:0]   burst_len_i,
    input  logic [N-1:0]    fifo_empty_i,
    input  logic [N*DW-1:0] fifo_data_i,
    output logic [N-1:0]    fifo_req_o,
    output logic            valid_o,
    output logic [DW-1:0]   data_o,
    output logic [CW-1:0]   ch_o,
    input  logic            ready_i,
    output logic [N-1:0]    grant_o,
    output logic            busy_o,
`ifdef FIFO_SCHED_STATS_EN
    output logic [N*32-1:0] words_cnt_o,
`endif
    output sched_state_t    state_o
);

    sched_state_t  state;
    logic [CW-1:0] ptr;
    logic [CW-1:0] g_idx;
    logic [BW-1:0] cnt;
    logic [BW-1:0] burst_clamped;

    logic [N-1:0]  arb_grant;
    logic [CW-1:0] arb_idx;
    logic          arb_any;

    logic          inflight;
    logic [CW-1:0] inflight_ch;
    logic [CW+DW-1:0] buf_mem [SCHED_BUF_DEPTH];
    logic          buf_rd;
    logic          buf_wr;
    logic [1:0]    occ;

    logic          issue;
    logic          push;
    logic          pop;
    logic          credit_ok;
    logic [2:0]    credit_sum;

    rr_arbiter #(
        .N  (N),
        .CW (CW)
    ) u_arb (
        .req_i   (~fifo_empty_i),
        .ptr_i   (ptr),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    // Burst length of zero means one word; anything above MAX_BURST saturates.
    always_comb begin
        if (burst_len_i == '0) begin
            burst_clamped = BW'(1);
        end else if (burst_len_i > BW'(MAX_BURST)) begin
            burst_clamped = BW'(MAX_BURST);
        end else begin
            burst_clamped = burst_len_i;
        end
    end

    // Credit check counts buffered words plus the one returning from the FIFO,
    // minus a word leaving this cycle; a new read needs a free slot after that.
    always_comb begin
        credit_sum = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
        credit_ok  = (credit_sum < 3'd2);
        issue      = (state == BURST) && en_i && !fifo_empty_i[g_idx] &&
                     (cnt != '0) && credit_ok;
        fifo_req_o = issue ? grant_o : '0;
    end

    assign push    = inflight;
    assign valid_o = (occ != 2'd0);
    assign pop     = valid_o && ready_i;
    assign {ch_o, data_o} = buf_mem[buf_rd];
    assign busy_o  = (state != IDLE) || inflight || valid_o;
    assign state_o = state;

    // Scheduler FSM: pick a channel, then issue reads until the burst budget,
    // the channel's data or the enable runs out.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= IDLE;
            ptr     <= CW'(N - 1);
            g_idx   <= '0;
            cnt     <= '0;
            grant_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en_i && arb_any) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (en_i && arb_any) begin
                        g_idx   <= arb_idx;
                        ptr     <= arb_idx;
                        cnt     <= burst_clamped;
                        grant_o <= arb_grant;
                        state   <= BURST;
                    end else begin
                        state <= IDLE;
                    end
                end
                BURST: begin
                    if (issue) begin
                        cnt <= cnt - BW'(1);
                    end
                    if ((issue && (cnt == BW'(1))) ||
                        (!issue && fifo_empty_i[g_idx]) || !en_i) begin
                        grant_o <= '0;
                        state   <= (en_i && arb_any) ? ARB : IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

    // Capture returning FIFO data one cycle after the read, tagged with the
    // channel latched at read time, into the 2-entry output buffer.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            inflight    <= 1'b0;
            inflight_ch <= '0;
            buf_rd      <= 1'b0;
            buf_wr      <= 1'b0;
            occ         <= 2'd0;
            for (int i = 0; i < SCHED_BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_ch <= g_idx;
            end
            if (push) begin
                buf_mem[buf_wr] <= {inflight_ch, fifo_data_i[inflight_ch*DW +: DW]};
                buf_wr          <= ~buf_wr;
            end
            if (pop) begin
                buf_rd <= ~buf_rd;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef FIFO_SCHED_STATS_EN
    logic [31:0] words_cnt [N];

    // Per-channel popped-word counters, free-running with natural wrap.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < N; i++) begin
                words_cnt[i] <= '0;
            end
        end else if (pop) begin
            words_cnt[ch_o] <= words_cnt[ch_o] + 32'd1;
        end
    end

    // Flatten the counters onto the output bus, channel k at [k*32 +: 32].
    always_comb begin
        words_cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            words_cnt_o[i*32 +: 32] = words_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Testbench for fifo_rr_scheduler: behavioural FIFOs feed the scheduler,
// a word-level round-robin model fills the expected queue, and a monitor
// compares every popped word against it.
module tb_fifo_rr_scheduler;
    import fifo_rr_scheduler_pkg::*;

    localparam int N         = 4;
    localparam int DW        = 32;
    localparam int MAX_BURST = 16;
    localparam int BW        = clogb2_f(MAX_BURST + 1);
    localparam int CW        = clogb2_f(N);

    // ---------------- clock / reset / DUT ----------------
    logic            clk_i = 1'b0;
    logic            arst_i = 1'b1;
    logic            en_i = 1'b0;
    logic [BW-1:0]   burst_len = '0;
    logic [N-1:0]    fifo_empty = '1;
    logic [N*DW-1:0] fifo_data = '0;
    logic [N-1:0]    fifo_req;
    logic            valid;
    logic [DW-1:0]   data;
    logic [CW-1:0]   ch;
    logic            ready = 1'b0;
    logic [N-1:0]    grant;
    logic            busy;
    sched_state_t    state_dbg;
`ifdef FIFO_SCHED_STATS_EN
    logic [N*32-1:0] words_cnt;
`endif

    always #5 clk_i = ~clk_i;

    fifo_rr_scheduler #(
        .N         (N),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .en_i         (en_i),
        .burst_len_i  (burst_len),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_req_o   (fifo_req),
        .valid_o      (valid),
        .data_o       (data),
        .ch_o         (ch),
        .ready_i      (ready),
        .grant_o      (grant),
        .busy_o       (busy),
`ifdef FIFO_SCHED_STATS_EN
        .words_cnt_o  (words_cnt),
`endif
        .state_o      (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int req_total = 0;
    int tb_ptr  = N - 1;
    int ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
    bit lat_arm = 0;
    int first_req = -1;
    int first_valid = -1;

    logic [DW-1:0]    fq [N][$];     // contents of the behavioural FIFOs
    logic [DW-1:0]    mq [N][$];     // model copy, consumed by model_run
    logic [CW+DW-1:0] pend_q[$];     // writes waiting for the next clock edge
    logic [CW+DW-1:0] exp_q[$];      // scoreboard expected queue
    int               ch_log[$];     // channel of every popped word

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Behavioural show-ahead-off FIFOs: a read at an edge updates data the
    // same edge; writes queued in pend_q land at the edge too.
    always @(posedge clk_i) begin
        if (arst_i) begin
            for (int k = 0; k < N; k++) fq[k].delete();
            pend_q.delete();
            fifo_empty <= '1;
        end else begin
            if (fifo_req != '0) begin
                check("req_onehot", {63'd0, $onehot(fifo_req)}, 64'd1);
            end
            for (int k = 0; k < N; k++) begin
                if (fifo_req[k]) begin
                    req_total++;
                    check("no_underflow", {63'd0, fq[k].size() != 0}, 64'd1);
                    if (fq[k].size() != 0) fifo_data[k*DW +: DW] <= fq[k].pop_front();
                end
            end
            while (pend_q.size() != 0) begin
                logic [CW+DW-1:0] e;
                e = pend_q.pop_front();
                fq[e[CW+DW-1:DW]].push_back(e[DW-1:0]);
            end
            for (int k = 0; k < N; k++) fifo_empty[k] <= (fq[k].size() == 0);
        end
    end

    // Downstream ready pattern, changed just after each rising edge.
    always @(posedge clk_i) begin
        #1;
        case (ready_mode)
            0:       ready = ($urandom_range(0, 3) != 0);
            1:       ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Monitor: every accepted output word is compared with the scoreboard.
    always @(negedge clk_i) begin
        if (!arst_i) begin
            if (lat_arm) begin
                if (fifo_req != '0 && first_req < 0) first_req = cyc;
                if (valid && first_valid < 0) first_valid = cyc;
            end
            if (valid && ready) begin
                ch_log.push_back(int'(ch));
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL word_unexpected: got ch=%0d data=%h, required no word", ch, data);
                end else begin
                    logic [CW+DW-1:0] e;
                    e = exp_q.pop_front();
                    if ({ch, data} !== e) begin
                        n_fail++;
                        $display("FAIL word_order: got ch=%0d data=%h, required ch=%0d data=%h",
                                 ch, data, e[CW+DW-1:DW], e[DW-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load(input int c, input int count);
        for (int i = 0; i < count; i++) begin
            logic [DW-1:0] d;
            d = $urandom;
            pend_q.push_back({CW'(c), d});
            mq[c].push_back(d);
        end
    endtask

    task automatic settle();
        repeat (2) @(negedge clk_i);
    endtask

    // Word-level reference: grant the next non-empty channel after the last
    // one granted and take min(effective burst, words left) from it.
    task automatic model_run(input int bl);
        int eff;
        int c;
        int take;
        bit found;
        bit more;
        eff  = (bl == 0) ? 1 : ((bl > MAX_BURST) ? MAX_BURST : bl);
        more = 1;
        while (more) begin
            found = 0;
            c = 0;
            for (int i = 1; i <= N; i++) begin
                if (!found && mq[(tb_ptr + i) % N].size() != 0) begin
                    found = 1;
                    c = (tb_ptr + i) % N;
                end
            end
            if (!found) begin
                more = 0;
            end else begin
                take = (mq[c].size() < eff) ? mq[c].size() : eff;
                for (int j = 0; j < take; j++) exp_q.push_back({CW'(c), mq[c].pop_front()});
                tb_ptr = c;
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        @(negedge clk_i);
        while ((exp_q.size() != 0 || busy) && guard < 3000) begin
            @(negedge clk_i);
            guard++;
        end
        check(name, {63'd0, guard < 3000}, 64'd1);
        check("idle_after_drain", 64'(state_dbg), 64'(IDLE));
    endtask

    // Load, predict, enable and drain one scenario.
    task automatic run_phase(input string name, input int bl);
        settle();
        burst_len = BW'(bl);
        model_run(bl);
        en_i = 1'b1;
        wait_drain(name);
        en_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t1_seq[12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
        int start;
        int guard;
        logic [CW+DW-1:0] held;

        // Reset state
        #1;
        check("rst_valid", {63'd0, valid}, 64'd0);
        check("rst_req", 64'(fifo_req), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        repeat (2) @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);

        // 1: three words per channel, burst of two, always ready
        ch_log.delete();
        for (int c = 0; c < N; c++) load(c, 3);
        run_phase("t1_drain", 2);
        check("t1_count", 64'(ch_log.size()), 64'd12);
        for (int i = 0; i < 12 && i < ch_log.size(); i++) check("t1_ch_seq", 64'(ch_log[i]), 64'(t1_seq[i]));

        // 2: only channel 2 holds data, long burst, read-to-valid latency
        ch_log.delete();
        load(2, 5);
        first_req = -1;
        first_valid = -1;
        lat_arm = 1;
        run_phase("t2_drain", 8);
        lat_arm = 0;
        check("t2_latency", 64'(first_valid - first_req), 64'd2);
        check("t2_count", 64'(ch_log.size()), 64'd5);

        // 4: zero burst length behaves as one word per grant
        ch_log.delete();
        load(0, 4);
        load(1, 4);
        run_phase("t4_drain", 0);
        check("t4_count", 64'(ch_log.size()), 64'd8);
        for (int i = 0; i < ch_log.size(); i++) check("t4_alternate", 64'(ch_log[i]), 64'(i % 2));

        // 3: downstream stalled for ten cycles with every channel busy
        ready_mode = 2;
        for (int c = 0; c < N; c++) load(c, 4);
        settle();
        burst_len = BW'(3);
        model_run(3);
        start = req_total;
        en_i = 1'b1;
        repeat (10) @(negedge clk_i);
        check("t3_reqs_stalled", 64'(req_total - start), 64'd2);
        check("t3_no_req_full", 64'(fifo_req), 64'd0);
        check("t3_valid_held", {63'd0, valid}, 64'd1);
        held = {ch, data};
        repeat (3) @(negedge clk_i);
        check("t3_output_stable", 64'({ch, data}), 64'(held));
        check("t3_reqs_still", 64'(req_total - start), 64'd2);
        ready_mode = 0;
        wait_drain("t3_drain");
        en_i = 1'b0;

        // 5: enable dropped after two reads of a long burst
        ready_mode = 1;
        load(0, 6);
        settle();
        burst_len = BW'(8);
        for (int j = 0; j < 2; j++) exp_q.push_back({CW'(0), mq[0].pop_front()});
        tb_ptr = 0;
        start = req_total;
        en_i = 1'b1;
        guard = 0;
        while (req_total - start < 2 && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        en_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("t5_reqs", 64'(req_total - start), 64'd2);
        check("t5_state_idle", 64'(state_dbg), 64'(IDLE));
        check("t5_words_out", 64'(exp_q.size()), 64'd0);
        check("t5_fifo_left", 64'(fq[0].size()), 64'd4);
        run_phase("t5_resume", 8);

        // Burst clamp: length above MAX_BURST saturates
        load(0, 18);
        load(1, 2);
        run_phase("clamp_drain", 31);

        // Randomised rounds with random burst lengths and backpressure
        ready_mode = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < N; c++) load(c, $urandom_range(0, 6));
            run_phase("rand_drain", $urandom_range(0, 20));
        end

        // 6: reset in the middle of a burst with a word on the output
        ready_mode = 1;
        load(1, 5);
        load(2, 5);
        settle();
        burst_len = BW'(4);
        model_run(4);
        en_i = 1'b1;
        guard = 0;
        while (!valid && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        check("t6_valid_seen", {63'd0, valid}, 64'd1);
        @(posedge clk_i);
        #2;
        arst_i = 1'b1;
        #1;
        check("t6_rst_valid", {63'd0, valid}, 64'd0);
        check("t6_rst_req", 64'(fifo_req), 64'd0);
        check("t6_rst_grant", 64'(grant), 64'd0);
        check("t6_rst_busy", {63'd0, busy}, 64'd0);
        en_i = 1'b0;
        exp_q.delete();
        for (int c = 0; c < N; c++) mq[c].delete();
        tb_ptr = N - 1;
        repeat (2) @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);
        for (int c = 0; c < N; c++) load(c, 2);
        settle();
        burst_len = BW'(1);
        model_run(1);
        en_i = 1'b1;
        guard = 0;
        while (grant == '0 && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        check("t6_first_grant", 64'(grant), 64'd1);
        wait_drain("t6_drain");
        en_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: stop a runaway simulation.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "simulation timeout");
    end

endmodule
